// File: rtl/pc_next_unit.sv
// IF-stage program counter with prioritised next-PC selection, boot hold and
// stall-time redirect buffering. Optional alignment trap: define PC_ALIGN_CHECK_EN.
module pc_next_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
  parameter int unsigned BOOT_HOLD    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        flush,
  output logic [31:0] pc_out,
  output logic        if_valid,
  output logic        redirect_pending,
  output logic        align_fault
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  typedef struct packed {
    logic        fault;
    logic [31:0] pc;
  } sel_t;

  localparam logic [1:0]  PRI_NONE   = 2'd0;
  localparam logic [1:0]  PRI_BRANCH = 2'd1;
  localparam logic [1:0]  PRI_JUMP   = 2'd2;
  localparam logic [1:0]  PRI_FLUSH  = 2'd3;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [3:0]  BOOT_LAST  = 4'(BOOT_HOLD - 1);

  // Flush always lands on EXC_VECTOR untouched; branch/jump targets go
  // through the alignment policy at the moment they are consumed.
  function automatic sel_t resolve(input logic [1:0] pri, input logic [31:0] tgt);
    sel_t res;
    res.fault = 1'b0;
    res.pc    = tgt;
    if (pri != PRI_FLUSH) begin
`ifdef PC_ALIGN_CHECK_EN
      if (tgt[1:0] != 2'b00) begin
        res.fault = 1'b1;
        res.pc    = EXC_VECTOR;
      end
`else
      res.pc = tgt & ALIGN_MASK;
`endif
    end
    return res;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_boot_cnt;
  logic [3:0]  w_boot_cnt_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic [1:0]  r_pend_pri;
  logic [1:0]  w_pend_pri_nxt;
  logic [31:0] r_pend_tgt;
  logic [31:0] w_pend_tgt_nxt;
  logic        r_pend;
  logic        w_pend_nxt;
  logic        r_fault;
  logic        w_fault_nxt;

  logic [1:0]  w_live_pri;
  logic [31:0] w_live_tgt;
  logic        w_live_wins;
  sel_t        w_sel;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_live_pri = PRI_NONE;
    w_live_tgt = 32'h0000_0000;
    if (flush) begin
      w_live_pri = PRI_FLUSH;
      w_live_tgt = EXC_VECTOR;
    end else if (jump) begin
      w_live_pri = PRI_JUMP;
      w_live_tgt = jump_target;
    end else if (branch_taken) begin
      w_live_pri = PRI_BRANCH;
      w_live_tgt = branch_target;
    end
  end

  // A live request beats the buffered one on equal priority.
  assign w_live_wins = (w_live_pri != PRI_NONE) && (w_live_pri >= r_pend_pri);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_boot_cnt_nxt = r_boot_cnt;
    w_pc_nxt       = r_pc;
    w_valid_nxt    = r_valid;
    w_pend_pri_nxt = r_pend_pri;
    w_pend_tgt_nxt = r_pend_tgt;
    w_pend_nxt     = r_pend;
    w_fault_nxt    = 1'b0;
    w_sel          = '0;

    unique case (r_state)
      S_BOOT: begin
        w_valid_nxt    = 1'b0;
        w_boot_cnt_nxt = r_boot_cnt + 4'd1;
        if (r_boot_cnt == BOOT_LAST) begin
          w_state_nxt = S_RUN;
          w_valid_nxt = 1'b1;
        end
      end

      S_RUN: begin
        if (stall) begin
          w_state_nxt = S_STALL;
          w_valid_nxt = 1'b0;
          if (w_live_pri != PRI_NONE) begin
            w_pend_pri_nxt = w_live_pri;
            w_pend_tgt_nxt = w_live_tgt;
            w_pend_nxt     = 1'b1;
          end
        end else if (w_live_pri != PRI_NONE) begin
          w_sel       = resolve(w_live_pri, w_live_tgt);
          w_pc_nxt    = w_sel.pc;
          w_fault_nxt = w_sel.fault;
        end else begin
          w_pc_nxt = r_pc + 32'd4;
        end
      end

      S_STALL: begin
        if (stall) begin
          if (w_live_wins) begin
            w_pend_pri_nxt = w_live_pri;
            w_pend_tgt_nxt = w_live_tgt;
            w_pend_nxt     = 1'b1;
          end
        end else begin
          // The held instruction was never issued, so release never adds 4.
          w_state_nxt = S_RUN;
          w_valid_nxt = 1'b1;
          if (w_live_wins) begin
            w_sel       = resolve(w_live_pri, w_live_tgt);
            w_pc_nxt    = w_sel.pc;
            w_fault_nxt = w_sel.fault;
          end else if (r_pend_pri != PRI_NONE) begin
            w_sel       = resolve(r_pend_pri, r_pend_tgt);
            w_pc_nxt    = w_sel.pc;
            w_fault_nxt = w_sel.fault;
          end
          w_pend_pri_nxt = PRI_NONE;
          w_pend_tgt_nxt = 32'h0000_0000;
          w_pend_nxt     = 1'b0;
        end
      end

      default: begin
        w_state_nxt    = S_BOOT;
        w_boot_cnt_nxt = 4'd0;
        w_pc_nxt       = RESET_VECTOR;
        w_valid_nxt    = 1'b0;
        w_pend_pri_nxt = PRI_NONE;
        w_pend_tgt_nxt = 32'h0000_0000;
        w_pend_nxt     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_boot_cnt <= 4'd0;
      r_pc       <= RESET_VECTOR;
      r_valid    <= 1'b0;
      r_pend_pri <= PRI_NONE;
      r_pend_tgt <= 32'h0000_0000;
      r_pend     <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_boot_cnt <= w_boot_cnt_nxt;
      r_pc       <= w_pc_nxt;
      r_valid    <= w_valid_nxt;
      r_pend_pri <= w_pend_pri_nxt;
      r_pend_tgt <= w_pend_tgt_nxt;
      r_pend     <= w_pend_nxt;
      r_fault    <= w_fault_nxt;
    end
  end

  assign pc_out           = r_pc;
  assign if_valid         = r_valid;
  assign redirect_pending = r_pend;
`ifdef PC_ALIGN_CHECK_EN
  assign align_fault      = r_fault;
`else
  assign align_fault      = 1'b0;
`endif

endmodule
